masked_subbytes_seq: RTL and testbench

Byte-serial sequencer that streams a 128-bit shared AES state through one pipelined masked S-box instance and collects the substituted bytes. It sits directly upstream of, and around, the shared S-box. It drives one shared byte per cycle into the S-box and tracks in-flight bytes with a valid/index shift pipeline matched to the S-box latency. It writes each result back into a shared result register and signals completion to the round controller.

---
 rtl/masked_subbytes_seq_pkg.sv | 20 ++
 rtl/masked_valid_delay.sv | 34 +++
 rtl/masked_subbytes_seq.sv | 121 ++++++++++++
 tb/tb_masked_subbytes_seq.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/masked_subbytes_seq_pkg.sv
// Shared definitions for the byte-serial masked SubBytes sequencer:
// FSM encoding, byte count, pipeline entry width and the share/byte slice helper.
package masked_subbytes_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    localparam int NUM_BYTES  = 16;
    localparam int PIPE_WIDTH = 5;  // {valid, idx[3:0]}

    // Bit offset of byte k of share i inside a flat shared 128-bit state.
    function automatic int byte_offset(input int share, input int k);
        return 128 * share + 8 * k;
    endfunction

endpackage

// File: rtl/masked_valid_delay.sv
// Shift register that follows each byte through the S-box.
// Each entry is {valid, idx}; the head comes out DEPTH cycles after the push.
module masked_valid_delay
    import masked_subbytes_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = PIPE_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stages [DEPTH];

    // NOTE: every stage is reset because its valid bit drives writes into
    // the result register; a stale valid after reset would corrupt it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < DEPTH; j++) begin
                stages[j] <= '0;
            end
        end else begin
            stages[0] <= din;
            for (int j = 1; j < DEPTH; j++) begin
                stages[j] <= stages[j-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/masked_subbytes_seq.sv
// Streams a shared 128-bit AES state byte by byte through one pipelined masked
// S-box and collects the substituted bytes; share i only ever reaches share i.
module masked_subbytes_seq
    import masked_subbytes_seq_pkg::*;
#(
    parameter int SHARES       = 2,
    parameter int SBOX_LATENCY = 4
) (
    input  logic                  ClkxCI,
    input  logic                  RstxBI,
    input  logic                  StartxSI,
    input  logic [128*SHARES-1:0] StatexDI,
    output logic [8*SHARES-1:0]   SboxInxDO,
    input  logic [8*SHARES-1:0]   SboxOutxDI,
    output logic                  FreshEnxSO,
    output logic [128*SHARES-1:0] StatexDO,
    output logic                  BusyxSO,
    output logic                  DonexSO
);

    // Packed views keep the flat port layout: share i, byte k at [128*i+8*k +: 8].
    typedef logic [SHARES-1:0][NUM_BYTES-1:0][7:0] shared_state_t;
    typedef logic [SHARES-1:0][7:0]                shared_byte_t;

    localparam logic [3:0] LAST_BYTE  = 4'(NUM_BYTES - 1);
    localparam logic [3:0] LAST_DRAIN = 4'(SBOX_LATENCY - 1);

    shared_state_t          state_in, state_buf, result;
    shared_byte_t           sbox_in, sbox_out;
    seq_state_t             state;
    logic [3:0]             cnt, cnt_next;
    logic                   busy, done, fresh;
    logic [PIPE_WIDTH-1:0]  push, head;

    assign state_in = StatexDI;
    assign sbox_out = SboxOutxDI;
    assign cnt_next = cnt + 4'd1;
    assign push     = (state == FEED) ? {1'b1, cnt} : '0;

    masked_valid_delay #(
        .DEPTH (SBOX_LATENCY),
        .WIDTH (PIPE_WIDTH)
    ) u_valid_delay (
        .clk   (ClkxCI),
        .rst_n (RstxBI),
        .din   (push),
        .dout  (head)
    );

    // NOTE: outputs are registered and loaded one edge ahead, so the S-box
    // byte for FEED cycle c is set up on the edge that enters that cycle.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            state     <= IDLE;
            cnt       <= '0;
            state_buf <= '0;
            result    <= '0;
            sbox_in   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fresh     <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (StartxSI) begin
                        state_buf <= state_in;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        fresh     <= 1'b1;
                        state     <= FEED;
                        for (int i = 0; i < SHARES; i++) begin
                            sbox_in[i] <= state_in[i][0];
                        end
                    end
                end
                FEED: begin
                    if (cnt == LAST_BYTE) begin
                        cnt     <= '0;
                        fresh   <= 1'b0;
                        sbox_in <= '0;
                        state   <= DRAIN;
                    end else begin
                        cnt <= cnt_next;
                        for (int i = 0; i < SHARES; i++) begin
                            sbox_in[i] <= state_buf[i][cnt_next];
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == LAST_DRAIN) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        cnt <= cnt_next;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Write-back of the byte whose S-box result is valid this cycle.
            if (head[PIPE_WIDTH-1]) begin
                for (int i = 0; i < SHARES; i++) begin
                    result[i][head[3:0]] <= sbox_out[i];
                end
            end
        end
    end

    assign SboxInxDO  = sbox_in;
    assign StatexDO   = result;
    assign FreshEnxSO = fresh;
    assign BusyxSO    = busy;
    assign DonexSO    = done;

endmodule

// File: tb/tb_masked_subbytes_seq.sv
// Directed bench: three sequencers (latency 4 with a behavioural masked AES
// S-box, latency 1 and 8 with identity S-boxes) checked against fixed vectors.
module tb_masked_subbytes_seq;
    import masked_subbytes_seq_pkg::*;

    localparam int LAT_A = 4;
    localparam int LAT_B = 1;
    localparam int LAT_C = 8;
    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] state_in;
    logic         mask_en;
    logic         start_s [3];
    logic         busy_s  [3];
    logic         done_s  [3];
    logic         fresh_s [3];
    logic [255:0] sout_s  [3];
    logic [15:0]  sbin_s  [3];
    logic [15:0]  sbout_s [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    masked_subbytes_seq #(.SHARES(2), .SBOX_LATENCY(LAT_A)) u_dut_a (
        .ClkxCI(clk), .RstxBI(rst_n), .StartxSI(start_s[0]), .StatexDI(state_in),
        .SboxInxDO(sbin_s[0]), .SboxOutxDI(sbout_s[0]), .FreshEnxSO(fresh_s[0]),
        .StatexDO(sout_s[0]), .BusyxSO(busy_s[0]), .DonexSO(done_s[0]));

    masked_subbytes_seq #(.SHARES(2), .SBOX_LATENCY(LAT_B)) u_dut_b (
        .ClkxCI(clk), .RstxBI(rst_n), .StartxSI(start_s[1]), .StatexDI(state_in),
        .SboxInxDO(sbin_s[1]), .SboxOutxDI(sbout_s[1]), .FreshEnxSO(fresh_s[1]),
        .StatexDO(sout_s[1]), .BusyxSO(busy_s[1]), .DonexSO(done_s[1]));

    masked_subbytes_seq #(.SHARES(2), .SBOX_LATENCY(LAT_C)) u_dut_c (
        .ClkxCI(clk), .RstxBI(rst_n), .StartxSI(start_s[2]), .StatexDI(state_in),
        .SboxInxDO(sbin_s[2]), .SboxOutxDI(sbout_s[2]), .FreshEnxSO(fresh_s[2]),
        .StatexDO(sout_s[2]), .BusyxSO(busy_s[2]), .DonexSO(done_s[2]));

    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
            b = b >> 1;
        end
        return p;
    endfunction

    // AES S-box: inverse as x^254 in GF(2^8), then the affine map.
    function automatic logic [7:0] aes_sbox(input logic [7:0] x);
        logic [7:0] r, base, e;
        r = 8'h01; base = x; e = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gf_mul(r, base);
            base = gf_mul(base, base);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    // Behavioural S-box pipelines; the masked one re-shares its output with a fresh mask.
    logic [7:0]  mask_a;
    logic [15:0] pipe_a [LAT_A];
    logic [15:0] pipe_b [LAT_B];
    logic [15:0] pipe_c [LAT_C];

    always @(posedge clk) begin
        mask_a    <= mask_en ? 8'($urandom) : 8'h00;
        pipe_a[0] <= {mask_a, aes_sbox(sbin_s[0][7:0] ^ sbin_s[0][15:8]) ^ mask_a};
        for (int j = 1; j < LAT_A; j++) pipe_a[j] <= pipe_a[j-1];
        pipe_b[0] <= sbin_s[1];
        pipe_c[0] <= sbin_s[2];
        for (int j = 1; j < LAT_C; j++) pipe_c[j] <= pipe_c[j-1];
    end

    assign sbout_s[0] = pipe_a[LAT_A-1];
    assign sbout_s[1] = pipe_b[LAT_B-1];
    assign sbout_s[2] = pipe_c[LAT_C-1];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One run on DUT d; returns the FEED-relative cycle of DonexSO (-1 on timeout).
    task automatic run(input int d, input logic [255:0] st, input int change_cyc,
                       output int done_cyc, output int fresh_cyc, output logic [255:0] res);
        done_cyc  = -1;
        fresh_cyc = 0;
        @(negedge clk);
        state_in   = st;
        start_s[d] = 1'b1;
        @(negedge clk);
        start_s[d] = 1'b0;
        for (int n = 0; n < 64; n++) begin
            if (n == change_cyc) state_in = ~st;
            if (fresh_s[d]) fresh_cyc++;
            if (done_s[d]) begin
                done_cyc = n;
                break;
            end
            @(negedge clk);
        end
        res = sout_s[d];
    endtask

    function automatic logic [127:0] recombine(input logic [255:0] v);
        return v[127:0] ^ v[255:128];
    endfunction

    initial begin
        int           dc, fc, first, second, pulses;
        logic [255:0] res, st_fips, st_id;
        logic [127:0] share1;

        rst_n    = 1'b0;
        state_in = '0;
        mask_en  = 1'b0;
        for (int d = 0; d < 3; d++) start_s[d] = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_state", sout_s[0], '0);
        check("rst_ctrl", {busy_s[0], done_s[0], fresh_s[0]}, '0);
        check("rst_sbox_in", sbin_s[0], '0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: all-zero shares, zero randomness
        run(0, '0, -1, dc, fc, res);
        check("t1_done_cycle", dc, 16 + LAT_A);
        check("t1_fresh_cycles", fc, 16);
        check("t1_result", recombine(res), {16{8'h63}});

        // 2: FIPS-197 round-1 state split into random shares
        mask_en = 1'b1;
        share1  = {$urandom, $urandom, $urandom, $urandom};
        st_fips = {share1, FIPS_IN ^ share1};
        run(0, st_fips, -1, dc, fc, res);
        check("t2_done_cycle", dc, 16 + LAT_A);
        check("t2_result", recombine(res), FIPS_OUT);

        // 3: identity S-box, latency 1 and 8; per-share bytes stay in place
        for (int k = 0; k < 16; k++) begin
            st_id[byte_offset(0, k) +: 8] = 8'(k);
            st_id[byte_offset(1, k) +: 8] = 8'(16 + k);
        end
        run(1, st_id, -1, dc, fc, res);
        check("t3_lat1_done_cycle", dc, 16 + LAT_B);
        check("t3_lat1_fresh_cycles", fc, 16);
        check("t3_lat1_result", res, st_id);
        run(2, st_id, -1, dc, fc, res);
        check("t3_lat8_done_cycle", dc, 16 + LAT_C);
        check("t3_lat8_fresh_cycles", fc, 16);
        check("t3_lat8_result", res, st_id);

        // 4: start held high across a whole run
        @(negedge clk);
        state_in   = st_fips;
        start_s[0] = 1'b1;
        @(negedge clk);
        first = -1; second = -1; pulses = 0;
        for (int i = 0; i < 64; i++) begin
            if (done_s[0]) begin
                pulses++;
                if (first < 0) first = i;
            end
            if (first >= 0 && i > first && busy_s[0]) begin
                second = i;
                break;
            end
            @(negedge clk);
        end
        start_s[0] = 1'b0;
        check("t4_first_done", first, 16 + LAT_A);
        check("t4_done_pulses", pulses, 1);
        check("t4_restart_cycle", second, 18 + LAT_A);
        dc = -1;
        for (int i = 0; i < 64; i++) begin
            if (done_s[0]) begin
                dc = i;
                break;
            end
            @(negedge clk);
        end
        check("t4_second_done", dc, 16 + LAT_A);
        check("t4_second_result", recombine(sout_s[0]), FIPS_OUT);

        // 5: reset in FEED cycle 7
        @(negedge clk);
        state_in   = {128'h0, 128'h0};
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        repeat (7) @(negedge clk);
        check("t5_in_feed", fresh_s[0], 1'b1);
        rst_n = 1'b0;
        #1;
        check("t5_rst_ctrl", {busy_s[0], done_s[0], fresh_s[0]}, '0);
        check("t5_rst_sbox_in", sbin_s[0], '0);
        check("t5_rst_state", sout_s[0], '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t5_idle_after_release", busy_s[0], 1'b0);
        run(0, st_fips, -1, dc, fc, res);
        check("t5_rerun_done_cycle", dc, 16 + LAT_A);
        check("t5_rerun_result", recombine(res), FIPS_OUT);

        // 6: input state changes in FEED cycle 3
        run(0, st_fips, 3, dc, fc, res);
        check("t6_done_cycle", dc, 16 + LAT_A);
        check("t6_result", recombine(res), FIPS_OUT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
